// File: rtl/layer_write_arbiter_pkg.sv
// Shared widths and state encoding for the layered frame-buffer write path.
// Latency: none, this file holds declarations only.
// Backpressure: none, this file holds declarations only.
package layer_pkg;

    localparam int LAYER_W = 3;
    localparam int COLOR_W = 8;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/layer_write_arbiter_rr_arbiter.sv
// Round-robin grant picker: first requester at or after the pointer, with wrap.
// Latency: the grant is combinational; the pointer updates on the clock edge after an enabled grant.
// Backpressure: when enable is low, the pointer holds and the caller must ignore the grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;

    // Search upward from the pointer and take the first active request.
    always_comb begin
        int unsigned j;
        logic        found;
        j         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Move the pointer just past the winner, only when the grant is used.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (enable && |req) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/layer_write_arbiter.sv
// Shares one frame-buffer write port among NUM_REQ clients and provides a full-layer clear sweep.
// Latency: an accepted write, or a clear pixel, appears on wr_* one cycle after it is issued.
// Backpressure: req_ready drops for every client while a clear starts or runs; clients hold valid.
module layer_write_arbiter
    import layer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int X_MAX   = 640,
    parameter int Y_MAX   = 480
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*LAYER_W-1:0]   req_layer,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOR_W-1:0]   req_color,
    input  logic                         clear_start,
    input  logic [LAYER_W-1:0]           clear_layer,
    output logic                         clear_busy,
    output logic                         clear_done,
    output logic                         wr_en,
    output logic [LAYER_W-1:0]           wr_layer,
    output logic [X_W-1:0]               wr_x,
    output logic [Y_W-1:0]               wr_y,
    output logic [COLOR_W-1:0]           wr_color
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    logic [X_W-1:0]       clr_x;
    logic [Y_W-1:0]       clr_y;
    logic [LAYER_W-1:0]   clr_layer_q;
    logic                 arb_en;
    logic                 xfer;
    logic                 clr_last;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;

    // A pending clear_start outranks every client in the same cycle.
    assign arb_en     = reset && (state == ARB) && !clear_start;
    assign req_ready  = arb_en ? grant : '0;
    assign xfer       = |(req_ready & req_valid);
    assign clr_last   = (clr_x == X_W'(X_MAX - 1)) && (clr_y == Y_W'(Y_MAX - 1));
    assign clear_busy = (state == CLEAR);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Mode and sweep counters; the last pixel hands the port back to arbitration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ARB;
            clr_x       <= '0;
            clr_y       <= '0;
            clr_layer_q <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (clear_start) begin
                        state       <= CLEAR;
                        clr_x       <= '0;
                        clr_y       <= '0;
                        clr_layer_q <= clear_layer;
                    end
                end
                CLEAR: begin
                    if (clr_last) begin
                        state <= ARB;
                        clr_x <= '0;
                        clr_y <= '0;
                    end else if (clr_x == X_W'(X_MAX - 1)) begin
                        clr_x <= '0;
                        clr_y <= clr_y + 1'b1;
                    end else begin
                        clr_x <= clr_x + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Registered write port; the fields hold their last value when nothing is written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_layer   <= '0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_color   <= '0;
            clear_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            clear_done <= 1'b0;
            if (state == CLEAR) begin
                wr_en      <= 1'b1;
                wr_layer   <= clr_layer_q;
                wr_x       <= clr_x;
                wr_y       <= clr_y;
                wr_color   <= '0;
                clear_done <= clr_last;
            end else if (xfer) begin
                wr_en    <= 1'b1;
                wr_layer <= req_layer[grant_idx*LAYER_W +: LAYER_W];
                wr_x     <= req_x[grant_idx*X_W +: X_W];
                wr_y     <= req_y[grant_idx*Y_W +: Y_W];
                wr_color <= req_color[grant_idx*COLOR_W +: COLOR_W];
            end
        end
    end

endmodule

// File: tb/tb_layer_write_arbiter.sv
module tb_layer_write_arbiter;
    import layer_pkg::*;

    localparam int N  = 4;
    localparam int XM = 4;
    localparam int YM = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    logic [N*LAYER_W-1:0]   req_layer = '0;
    logic [N*X_W-1:0]       req_x = '0;
    logic [N*Y_W-1:0]       req_y = '0;
    logic [N*COLOR_W-1:0]   req_color = '0;
    logic                   clear_start = 1'b0;
    logic [LAYER_W-1:0]     clear_layer = '0;
    logic                   clear_busy, clear_done, wr_en;
    logic [LAYER_W-1:0]     wr_layer;
    logic [X_W-1:0]         wr_x;
    logic [Y_W-1:0]         wr_y;
    logic [COLOR_W-1:0]     wr_color;

    int vectors = 0;
    int errors  = 0;

    layer_write_arbiter #(.NUM_REQ(N), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_layer(req_layer), .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .clear_start(clear_start), .clear_layer(clear_layer),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .wr_en(wr_en), .wr_layer(wr_layer), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input int l, input int x, input int y, input int c);
        req_layer[i*LAYER_W +: LAYER_W] = LAYER_W'(l);
        req_x[i*X_W +: X_W]             = X_W'(x);
        req_y[i*Y_W +: Y_W]             = Y_W'(y);
        req_color[i*COLOR_W +: COLOR_W] = COLOR_W'(c);
    endtask

    // Reference model: clear is a list of pixel indices 0..XM*YM-1; arbitration is "first valid from ptr".
    logic               m_known = 0, n_known = 0;
    int                 m_ptr = 0, n_ptr = 0;
    logic               m_clr = 0, n_clr = 0;
    int                 m_idx = 0, n_idx = 0;
    int                 m_clayer = 0, n_clayer = 0;
    logic               e_en = 0, n_en = 0, e_done = 0, n_done = 0;
    int                 e_layer = 0, e_x = 0, e_y = 0, e_color = 0;
    int                 n_layer = 0, n_x = 0, n_y = 0, n_color = 0;

    // Compare DUT against model mid-cycle, then work out the model's next cycle.
    always @(negedge clk) begin
        logic [N-1:0] er;
        int           g;
        er = '0;
        g  = -1;
        n_ptr = m_ptr; n_clr = m_clr; n_idx = m_idx; n_clayer = m_clayer;
        n_en = 0; n_done = 0;
        n_layer = e_layer; n_x = e_x; n_y = e_y; n_color = e_color;
        if (!reset) begin
            n_ptr = 0; n_clr = 0; n_idx = 0; n_clayer = 0;
            n_layer = 0; n_x = 0; n_y = 0; n_color = 0;
        end else if (m_clr) begin
            n_en = 1; n_layer = m_clayer; n_x = m_idx % XM; n_y = m_idx / XM; n_color = 0;
            if (m_idx == XM*YM - 1) begin
                n_clr = 0; n_done = 1; n_idx = 0;
            end else begin
                n_idx = m_idx + 1;
            end
        end else if (clear_start) begin
            n_clr = 1; n_idx = 0; n_clayer = int'(clear_layer);
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                er[g]   = 1'b1;
                n_en    = 1;
                n_layer = int'(req_layer[g*LAYER_W +: LAYER_W]);
                n_x     = int'(req_x[g*X_W +: X_W]);
                n_y     = int'(req_y[g*Y_W +: Y_W]);
                n_color = int'(req_color[g*COLOR_W +: COLOR_W]);
                n_ptr   = (g + 1) % N;
            end
        end
        if (m_known) begin
            chk("model_req_ready", 32'(req_ready), 32'(er));
            chk("model_wr_en", 32'(wr_en), 32'(e_en));
            chk("model_wr_layer", 32'(wr_layer), e_layer);
            chk("model_wr_x", 32'(wr_x), e_x);
            chk("model_wr_y", 32'(wr_y), e_y);
            chk("model_wr_color", 32'(wr_color), e_color);
            chk("model_clear_busy", 32'(clear_busy), 32'(m_clr));
            chk("model_clear_done", 32'(clear_done), 32'(e_done));
        end
        n_known = 1;
    end

    // Commit the model's next state on the same edge the DUT updates.
    always @(posedge clk) begin
        m_known = n_known; m_ptr = n_ptr; m_clr = n_clr; m_idx = n_idx; m_clayer = n_clayer;
        e_en = n_en; e_done = n_done;
        e_layer = n_layer; e_x = n_x; e_y = n_y; e_color = n_color;
    end

    initial begin
        int gs [5] = '{0, 1, 2, 3, 0};
        int ex [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int ey [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int nw, nd;

        for (int i = 0; i < N; i++) set_client(i, i, 10 + i, 20 + i, 8'h30 + i);

        // Reset with every client requesting.
        reset = 0; req_valid = 4'b1111;
        cyc(); cyc();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_busy", 32'(clear_busy), 32'h0);
        chk("rst_done", 32'(clear_done), 32'h0);
        chk("rst_wr_x", 32'(wr_x), 32'h0);
        cyc();
        reset = 1;

        // All four valid for five cycles: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << gs[k]));
            if (k > 0) begin
                chk("rr_wr_en", 32'(wr_en), 32'h1);
                chk("rr_wr_x", 32'(wr_x), 32'(10 + gs[k-1]));
                chk("rr_wr_color", 32'(wr_color), 32'(8'h30 + gs[k-1]));
            end
            cyc();
        end
        req_valid = '0;
        #1;
        chk("rr_last_wr_x", 32'(wr_x), 32'd10);
        chk("rr_last_wr_layer", 32'(wr_layer), 32'd0);

        // Single client 2 request.
        cyc();
        set_client(2, 3, 5, 7, 8'hAA);
        req_valid = 4'b0100;
        #1;
        chk("c2_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        #1;
        chk("c2_wr_en", 32'(wr_en), 32'h1);
        chk("c2_wr_layer", 32'(wr_layer), 32'd3);
        chk("c2_wr_x", 32'(wr_x), 32'd5);
        chk("c2_wr_y", 32'(wr_y), 32'd7);
        chk("c2_wr_color", 32'(wr_color), 32'hAA);

        // Clear of layer 5 with client 1 waiting throughout.
        cyc();
        req_valid = 4'b0010; clear_start = 1; clear_layer = 3'd5;
        #1;
        chk("clr_start_ready", 32'(req_ready), 32'h0);
        cyc();
        clear_start = 0;
        #1;
        chk("clr_c1_ready", 32'(req_ready), 32'h0);
        chk("clr_c1_busy", 32'(clear_busy), 32'h1);
        chk("clr_c1_wr_en", 32'(wr_en), 32'h0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            #1;
            chk("clr_wr_en", 32'(wr_en), 32'h1);
            chk("clr_wr_layer", 32'(wr_layer), 32'd5);
            chk("clr_wr_x", 32'(wr_x), 32'(ex[k]));
            chk("clr_wr_y", 32'(wr_y), 32'(ey[k]));
            chk("clr_wr_color", 32'(wr_color), 32'h0);
            chk("clr_done", 32'(clear_done), 32'(k == 7));
            chk("clr_ready", 32'(req_ready), (k == 7) ? 32'h2 : 32'h0);
        end
        cyc();
        req_valid = '0;
        #1;
        chk("post_clr_wr_en", 32'(wr_en), 32'h1);
        chk("post_clr_wr_x", 32'(wr_x), 32'd11);
        chk("post_clr_wr_layer", 32'(wr_layer), 32'd1);
        chk("post_clr_done", 32'(clear_done), 32'h0);

        // Reset after three clear writes abandons the clear.
        cyc();
        clear_start = 1; clear_layer = 3'd2;
        cyc();
        clear_start = 0;
        cyc(); cyc(); cyc();
        #1;
        chk("abort_third_x", 32'(wr_x), 32'd2);
        reset = 0;
        cyc();
        #1;
        chk("abort_wr_en", 32'(wr_en), 32'h0);
        chk("abort_busy", 32'(clear_busy), 32'h0);
        reset = 1;
        set_client(0, 6, 9, 4, 8'h5C);
        req_valid = 4'b0001;
        #1;
        chk("abort_c0_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        #1;
        chk("abort_c0_wr_x", 32'(wr_x), 32'd9);
        chk("abort_c0_wr_color", 32'(wr_color), 32'h5C);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("abort_no_resume", 32'(wr_en), 32'h0);
        end

        // clear_start pulsed mid-sweep is ignored.
        cyc();
        clear_start = 1; clear_layer = 3'd7;
        nw = 0; nd = 0;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            clear_start = (c == 3);
            #1;
            nw += int'(wr_en);
            nd += int'(clear_done);
            if (wr_en) chk("mid_wr_layer", 32'(wr_layer), 32'd7);
        end
        clear_start = 0;
        chk("mid_clear_writes", nw, 8);
        chk("mid_clear_done_pulses", nd, 1);

        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/layer_write_arbiter.md
Name: layer_write_arbiter

Overview:
- Shares the single write port of the layered pixel memory between NUM_REQ drawing clients: cursor pen, shape engine, and others.
- Clients submit pixel writes to a chosen layer with a valid/ready handshake. Arbitration is round-robin.
- Contains a layer-clear sequencer. On command it takes over the port and writes colour 0 to every pixel of one layer.
- Sits between the drawing front-ends, with layer chosen by the layer selector, and the frame-buffer write port.

Parameters:
- NUM_REQ, 4: number of requesting clients.
- X_MAX, 640: pixels per row; the clear sweep covers x = 0..X_MAX-1.
- Y_MAX, 480: rows; the clear sweep covers y = 0..Y_MAX-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- req_valid  in  NUM_REQ  per-client write request
- req_ready  out  NUM_REQ  per-client accept; combinational; at most one bit high
- req_layer  in  NUM_REQ*LAYER_W  per-client target layer, packed, client 0 in the LSBs
- req_x  in  NUM_REQ*X_W  per-client x
- req_y  in  NUM_REQ*Y_W  per-client y
- req_color  in  NUM_REQ*COLOR_W  per-client pixel value
- clear_start  in  1  start a layer clear (sampled only in ARB)
- clear_layer  in  LAYER_W  layer to clear; latched with clear_start
- clear_busy  out  1  high while the clear sweep is generating writes
- clear_done  out  1  one-cycle pulse marking the final clear write
- wr_en  out  1  memory write strobe
- wr_layer  out  LAYER_W  memory layer
- wr_x  out  X_W  memory x
- wr_y  out  Y_W  memory y
- wr_color  out  COLOR_W  memory data

Behaviour:
- Reset (reset==0 at a clk edge), including mid-operation:
  - state=ARB, rr pointer=0, clear counters=0.
  - wr_en=0 and wr_layer/x/y/color=0.
  - clear_busy=0, clear_done=0, req_ready=0.
  - An in-progress clear is abandoned, not resumed.
- States: ARB and CLEAR (enum state_t).
- ARB, no clear_start:
  - Grant the first i with req_valid[i]=1, searching from the pointer upward with wrap.
  - Drive req_ready[i]=1 combinationally. The transfer happens when valid&ready.
  - After grant i, pointer becomes (i+1) mod NUM_REQ. With no valid, the pointer holds.
- Write latency is 1 cycle. A transfer accepted in cycle n appears on wr_* with wr_en=1 in cycle n+1. If there is no transfer in cycle n, wr_en=0 in n+1.
- wr_* is registered. wr_layer/x/y/color hold their last value when wr_en=0.
- ARB with clear_start=1:
  - Clear wins. All req_ready=0 that cycle.
  - Latch clear_layer, zero the x/y counters, and go to CLEAR.
- CLEAR:
  - All req_ready=0; clear_busy=1.
  - Each cycle, issue a write of (latched layer, x, y, colour 0). It appears on wr_* the next cycle.
  - x increments; at X_MAX-1 it wraps to 0 and y increments.
  - The cycle that issues (X_MAX-1, Y_MAX-1) returns to ARB.
- Clear timing:
  - The sweep produces exactly X_MAX*Y_MAX consecutive wr_en cycles.
  - The first write, (0,0), is on wr_* two cycles after clear_start was sampled.
  - clear_done=1 in the cycle wr_* shows (X_MAX-1, Y_MAX-1).
  - In that same cycle state is ARB, so a grant can occur and wr_en stays continuous.
- clear_start while in CLEAR is ignored. A held clear_start triggers a new clear on the first ARB cycle.
- Requests pending during CLEAR are not dropped. Clients hold valid; arbitration resumes from the pointer saved before the clear.
- The pointer is unchanged by a clear.

Decomposition:
- Package layer_pkg: LAYER_W=3, COLOR_W=8, X_W=10, Y_W=9, and typedef enum state_t {ARB, CLEAR}.
- Sub-module rr_arbiter:
  - Inputs: req, enable. Outputs: one-hot grant, grant index.
  - Owns the pointer register and advances it only on an enabled grant.

Test Plan (X_MAX=4, Y_MAX=2 where a clear is used):
- Reset held low for 2 cycles with all req_valid=1 -> req_ready=0000, wr_en=0, clear_busy=0, clear_done=0. After release, the first grant is client 0.
- Only client 2 valid, layer=3, x=5, y=7, color=8'hAA -> req_ready=0100 that cycle. Next cycle: wr_en=1, wr_layer=3, wr_x=5, wr_y=7, wr_color=8'hAA.
- All four valid continuously for 5 cycles -> grants 0,1,2,3,0. wr_en=1 every cycle from the second onward, wr fields matching each grantee.
- Clear of layer 5 with client 1 valid throughout:
  - clear_start and req_valid together -> no grant that cycle.
  - Then 8 writes, layer 5, colour 0, in order (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(3,1).
  - clear_done high only with (3,1). Client 1 is granted in that cycle, and its write follows next cycle.
- Reset asserted after 3 clear writes -> next cycle wr_en=0, clear_busy=0. After release the clear does not resume, and a client 0 request is granted.
- clear_start pulsed mid-CLEAR -> ignored. Exactly 8 clear writes and a single clear_done pulse.
